// File: rtl/bram_arbiter_2p_if.sv
// Request/response bundle for one requester of the shared block RAM.
// The requester drives through the master modport and the arbiter answers through the slave modport.
interface bram_arbiter_2p_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/bram_arbiter_2p.sv
// Round-robin arbiter sharing one single-port BRAM (two-stage read path) between two requesters.
// Issued reads are tracked by a two-stage tag pipeline so the data returns to its requester two cycles after grant.
module bram_arbiter_2p #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bram_arbiter_2p_if.slave      port0,
  bram_arbiter_2p_if.slave      port1,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_di,
  input  logic [DATA_WIDTH-1:0] ram_do,
  output logic                  ram_rst,
  output logic                  ram_rst2,
  output logic                  ram_en2
);

  typedef struct packed {
    logic valid;
    logic port;
  } tag_t;

  logic r_last_grant;
  tag_t r_tag_a;
  tag_t r_tag_b;

  logic w_gnt0;
  logic w_gnt1;
  logic w_rd_issue;

  // No access is issued while reset is being sampled.
  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (rst_n) begin
      if (port0.req_valid && port1.req_valid) begin
        w_gnt0 = r_last_grant;
        w_gnt1 = !r_last_grant;
      end else begin
        w_gnt0 = port0.req_valid;
        w_gnt1 = port1.req_valid;
      end
    end
  end

  assign port0.req_ready = w_gnt0;
  assign port1.req_ready = w_gnt1;

  always_comb begin
    ram_en   = w_gnt0 || w_gnt1;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_di   = '0;
    if (w_gnt1) begin
      ram_we   = port1.req_we;
      ram_addr = port1.req_addr;
      ram_di   = port1.req_wdata;
    end else if (w_gnt0) begin
      ram_we   = port0.req_we;
      ram_addr = port0.req_addr;
      ram_di   = port0.req_wdata;
    end
  end

  assign w_rd_issue = (w_gnt0 && !port0.req_we) || (w_gnt1 && !port1.req_we);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_tag_a      <= '0;
      r_tag_b      <= '0;
    end else begin
      if (w_gnt0 || w_gnt1) begin
        r_last_grant <= w_gnt1;
      end
      r_tag_a <= '{valid: w_rd_issue, port: w_gnt1};
      r_tag_b <= r_tag_a;
    end
  end

  // Stage A lines up with the RAM's array register, stage B with its output register.
  assign ram_en2 = r_tag_a.valid;

  assign port0.rsp_valid = r_tag_b.valid && !r_tag_b.port;
  assign port1.rsp_valid = r_tag_b.valid &&  r_tag_b.port;
  assign port0.rsp_rdata = ram_do;
  assign port1.rsp_rdata = ram_do;

  assign ram_rst  = !rst_n;
  assign ram_rst2 = !rst_n;

endmodule

// File: tb/tb_bram_arbiter_2p.sv
// Self-checking bench for bram_arbiter_2p: directed scenarios plus randomized traffic against a
// transaction-level model (request queues, memory array, queue of expected responses with due cycle).
module tb_bram_arbiter_2p;
  localparam int DW = 32;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bram_arbiter_2p_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) p0 ();
  bram_arbiter_2p_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) p1 ();

  logic          ram_en, ram_we, ram_rst, ram_rst2, ram_en2;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di, ram_do;

  bram_arbiter_2p #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .port0    (p0),
    .port1    (p1),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_di   (ram_di),
    .ram_do   (ram_do),
    .ram_rst  (ram_rst),
    .ram_rst2 (ram_rst2),
    .ram_en2  (ram_en2)
  );

  // Behavioural single-port RAM with array register and output-enable register.
  logic [DW-1:0] ram_mem [2**AW];
  logic [DW-1:0] ram_q1, ram_q2;
  always @(posedge clk) begin
    if (ram_rst) ram_q1 <= '0;
    else if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_di;
      ram_q1 <= ram_mem[ram_addr];
    end
    if (ram_rst2) ram_q2 <= '0;
    else if (ram_en2) ram_q2 <= ram_q1;
  end
  assign ram_do = ram_q2;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct {
    logic          port;
    int            due;
    logic [DW-1:0] data;
  } rsp_t;

  req_t          rq0[$];
  req_t          rq1[$];
  rsp_t          pend[$];
  logic [DW-1:0] m_mem [int];
  logic          pres[2];
  logic          m_last;
  logic          m_prev_read;
  logic          gappy;
  int            cyc;
  int            n_cmp;
  int            n_err;

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", tag, cyc, act, exp);
    end
  endtask

  task automatic push(input int port, input logic we, input int addr, input logic [DW-1:0] wdata);
    req_t r;
    r.we    = we;
    r.addr  = AW'(addr);
    r.wdata = wdata;
    if (port == 0) rq0.push_back(r);
    else rq1.push_back(r);
  endtask

  task automatic drive_inputs();
    if (!pres[0] && rq0.size() > 0 && (!gappy || $urandom_range(0, 1) == 1)) pres[0] = 1'b1;
    if (!pres[1] && rq1.size() > 0 && (!gappy || $urandom_range(0, 1) == 1)) pres[1] = 1'b1;
    p0.req_valid = pres[0];
    p0.req_we    = pres[0] ? rq0[0].we    : 1'b0;
    p0.req_addr  = pres[0] ? rq0[0].addr  : '0;
    p0.req_wdata = pres[0] ? rq0[0].wdata : '0;
    p1.req_valid = pres[1];
    p1.req_we    = pres[1] ? rq1[0].we    : 1'b0;
    p1.req_addr  = pres[1] ? rq1[0].addr  : '0;
    p1.req_wdata = pres[1] ? rq1[0].wdata : '0;
  endtask

  // One clock cycle: drive, check combinational and response outputs, then advance the model at the edge.
  task automatic run_cycle();
    logic          g0, g1, e0, e1;
    logic          x_we;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_di, x_rd;
    req_t          f;
    rsp_t          r;
    drive_inputs();
    #1;
    g0 = 1'b0;
    g1 = 1'b0;
    if (rst_n) begin
      if (pres[0] && pres[1]) begin
        g0 = (m_last == 1'b1);
        g1 = (m_last == 1'b0);
      end else begin
        g0 = pres[0];
        g1 = pres[1];
      end
    end
    x_we = 1'b0; x_addr = '0; x_di = '0;
    if (g0) begin x_we = rq0[0].we; x_addr = rq0[0].addr; x_di = rq0[0].wdata; end
    if (g1) begin x_we = rq1[0].we; x_addr = rq1[0].addr; x_di = rq1[0].wdata; end
    check("req0_ready", DW'(p0.req_ready), DW'(g0));
    check("req1_ready", DW'(p1.req_ready), DW'(g1));
    check("ram_en", DW'(ram_en), DW'(g0 | g1));
    check("ram_we", DW'(ram_we), DW'(x_we));
    check("ram_addr", DW'(ram_addr), DW'(x_addr));
    check("ram_di", ram_di, x_di);
    check("ram_en2", DW'(ram_en2), DW'(m_prev_read));
    check("ram_rst", DW'({ram_rst, ram_rst2}), DW'({!rst_n, !rst_n}));
    if (rst_n) begin
      e0 = 1'b0; e1 = 1'b0; x_rd = '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        r = pend.pop_front();
        if (r.port) e1 = 1'b1;
        else e0 = 1'b1;
        x_rd = r.data;
      end
      check("rsp0_valid", DW'(p0.rsp_valid), DW'(e0));
      check("rsp1_valid", DW'(p1.rsp_valid), DW'(e1));
      if (e0) check("rsp0_rdata", p0.rsp_rdata, x_rd);
      if (e1) check("rsp1_rdata", p1.rsp_rdata, x_rd);
    end
    @(posedge clk);
    if (!rst_n) begin
      pend.delete();
      m_last      = 1'b1;
      m_prev_read = 1'b0;
    end else begin
      m_prev_read = 1'b0;
      if (g0 || g1) begin
        if (g1) begin f = rq1.pop_front(); pres[1] = 1'b0; end
        else begin f = rq0.pop_front(); pres[0] = 1'b0; end
        m_last = g1;
        if (f.we) m_mem[int'(f.addr)] = f.wdata;
        else begin
          r.port = g1;
          r.due  = cyc + 2;
          r.data = m_mem.exists(int'(f.addr)) ? m_mem[int'(f.addr)] : 'x;
          pend.push_back(r);
          m_prev_read = 1'b1;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int extra);
    int budget = 300;
    while ((rq0.size() > 0 || rq1.size() > 0 || pend.size() > 0) && budget > 0) begin
      run_cycle();
      budget--;
    end
    if (budget == 0) check("drain_timeout", 32'd1, 32'd0);
    repeat (extra) run_cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    pres[0] = 1'b0; pres[1] = 1'b0;
    m_last = 1'b1; m_prev_read = 1'b0; gappy = 1'b0;
    p0.req_valid = 1'b0; p0.req_we = 1'b0; p0.req_addr = '0; p0.req_wdata = '0;
    p1.req_valid = 1'b0; p1.req_we = 1'b0; p1.req_addr = '0; p1.req_wdata = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Preload addresses 0..15 with value = address.
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) push(0, 1'b1, a, DW'(a));
    drain(2);

    // Reset with both ports requesting, then contention: grants alternate starting at port 0.
    for (int a = 0; a < 4; a++) begin
      push(0, 1'b0, a, '0);
      push(1, 1'b0, a + 8, '0);
    end
    rst_n = 1'b0;
    repeat (2) run_cycle();
    check("rdata0_after_reset", p0.rsp_rdata, '0);
    check("rdata1_after_reset", p1.rsp_rdata, '0);
    check("rsp_valid_in_reset", DW'({p0.rsp_valid, p1.rsp_valid}), '0);
    rst_n = 1'b1;
    drain(2);

    // Write then read of the same address on port 0.
    push(0, 1'b1, 5, 32'hDEAD_BEEF);
    push(0, 1'b0, 5, '0);
    drain(2);

    // Port 1 alone, four back-to-back reads.
    for (int a = 12; a < 16; a++) push(1, 1'b0, a, '0);
    drain(2);

    // Read in flight dropped by reset, then a fresh read after release.
    push(0, 1'b0, 7, '0);
    run_cycle();
    rst_n = 1'b0;
    run_cycle();
    rst_n = 1'b1;
    repeat (4) run_cycle();
    push(0, 1'b0, 7, '0);
    drain(2);

    // Write-only burst from both ports.
    push(0, 1'b1, 1, $urandom());
    push(1, 1'b1, 2, $urandom());
    push(0, 1'b1, 3, $urandom());
    drain(3);

    // Randomized traffic over the preloaded address range.
    gappy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (rq0.size() < 4 && $urandom_range(0, 2) != 0)
        push(0, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom());
      if (rq1.size() < 4 && $urandom_range(0, 2) != 0)
        push(1, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom());
      run_cycle();
    end
    drain(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bram_arbiter_2p.md
# bram_arbiter_2p

Two-requester arbiter that shares one single-port block RAM between two masters, e.g. the core's load/store unit on port 0 and the program loader on port 1. The RAM has a two-stage registered read path: an array output register followed by an output-enable register. The block does three things:
- grants one access per cycle with round-robin fairness;
- drives the RAM's enable, write, address and data inputs;
- tracks every issued read through a 2-stage tag pipeline, so the read data is returned to the requester that issued it exactly two cycles after the grant.

## Interface
Parameters:
- DATA_WIDTH, 32, RAM word width
- ADDR_WIDTH, 10, RAM word-address width

Ports:
- clk  in  1  single clock for the block and the RAM
- rst_n  in  1  reset, synchronous, active-low
- req0_valid  in  1  port 0 request present
- req0_ready  out  1  port 0 request granted this cycle
- req0_we  in  1  port 0 write (1) / read (0)
- req0_addr  in  ADDR_WIDTH  port 0 word address
- req0_wdata  in  DATA_WIDTH  port 0 write data
- rsp0_valid  out  1  port 0 read data valid
- rsp0_rdata  out  DATA_WIDTH  port 0 read data
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same directions, widths and meanings as port 0, for port 1
- ram_en  out  1  RAM stage-1 enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_di  out  DATA_WIDTH  RAM write data
- ram_do  in  DATA_WIDTH  RAM final output register
- ram_rst  out  1  RAM stage-1 output reset (active-high)
- ram_rst2  out  1  RAM stage-2 output reset (active-high)
- ram_en2  out  1  RAM stage-2 enable

## Operation
- **Grant logic** (combinational from the request valids and the last_grant register):
  - Only one port valid: that port is granted.
  - Both ports valid: the port not equal to last_grant is granted.
  - Neither port valid: no grant.
  - reqN_ready = grant to port N. reqN_ready is never asserted without reqN_valid.
  - A request is accepted in any cycle where valid && ready. A requester holds its request fields stable until accepted.
- **last_grant**: a 1-bit register, updated to the granted port on every grant, held otherwise. Reset value is 1, so port 0 wins the first contention.
- **RAM drive** (combinational mux of the granted port):
  - ram_en = any grant.
  - ram_we = granted port's we.
  - ram_addr and ram_di = granted port's addr and wdata.
  - With no grant: ram_en = 0, ram_we = 0, ram_addr = 0, ram_di = 0.
- **Tag pipeline**: stage A and stage B, each holding {valid, port}.
  - Stage A loads {grant && !we, granted port} every cycle.
  - Stage B loads stage A every cycle.
- **Read responses**:
  - ram_en2 = stage A valid.
  - rspN_valid = stage B valid && stage B port == N.
  - rsp0_rdata = rsp1_rdata = ram_do. The data is meaningful only while the matching rsp valid is high.
- **Writes** produce no response. Read-during-write data from the RAM is discarded.
- **Response flow control**: responses have no backpressure; requesters must accept rsp in the cycle it is presented.
- **RAM resets**: ram_rst = ram_rst2 = !rst_n.

## Timing
- **Reset** (rst_n = 0 sampled at a clk edge):
  - Stage A and stage B valid cleared.
  - last_grant set to 1.
  - The RAM output registers clear via ram_rst and ram_rst2.
  - During reset, req0_ready and req1_ready are forced to 0, so no accesses are issued.
- **Reset values of outputs**: req*_ready 0, rsp*_valid 0, rsp*_rdata 0 (the RAM output is cleared), ram_en 0, ram_we 0, ram_en2 0.
- **Read latency**: a read granted in cycle T is sampled by the RAM at the end of T. Its response is visible during cycle T+2 (rsp valid high for exactly one cycle).
- **Throughput**: one access per cycle total; back-to-back reads give one response per cycle, in grant order.
- **Contention**: under continuous requests from both ports, grants strictly alternate 0,1,0,1,...
- **Write then read of the same address**: a write granted in T followed by a read of that address granted in T+1 returns the new data at T+3.
- **Reset mid-operation**: reads in flight are dropped; no rsp valid is asserted for them after reset.
- **Idle cycles**: do not disturb last_grant.

## Test plan
- Reset with both ports valid -> req0_ready = req1_ready = 0 during reset. In the first cycle after release, port 0 is granted (last_grant = 1).
- Port 0 writes 0xDEADBEEF to address 5 at T, then reads address 5 at T+1 -> rsp0_valid = 1 at T+3 with rsp0_rdata = 0xDEADBEEF; rsp1_valid stays 0.
- Both ports issue continuous reads (port 0 addresses 0..3, port 1 addresses 8..11, preloaded with value = address) -> grants alternate 0,1,0,1,…. Each rsp arrives 2 cycles after its grant on the correct port with the matching value.
- Port 1 alone issues 4 back-to-back reads -> ready is held high for 4 cycles and rsp1_valid is high for 4 consecutive cycles starting 2 cycles after the first grant.
- A read is granted at T and rst_n is asserted at T+1 -> no rsp valid occurs at T+2 or later. After release, a new read returns correctly.
- A write-only burst of 3 writes -> rsp0_valid and rsp1_valid stay 0 throughout. ram_en2 stays 0.
